cla_4_bits: RTL and testbench

// - 4-bit carry-lookahead adder: Sum/Cout = A + B + Cin, all carries derived in parallel from
//   per-bit generate/propagate terms (no ripple chain).
// - Leaf arithmetic cell; group PG/GG outputs let a parent build 16-bit two-level CLA adders.
// - Combinational result for immediate use, plus a registered copy for pipelined consumers.

---
 rtl/cla_4_bits_pkg.sv | 4 +
 rtl/cla_4_bits_pg.sv | 43 ++++
 rtl/cla_4_bits.sv | 53 +++++
 tb/tb_cla_4_bits.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cla_4_bits_pkg.sv
// Shared types for the 4-bit carry-lookahead adder slice.
package cla_4_bits_pkg;
  typedef logic [3:0] nibble_t;
endpackage

// File: rtl/cla_4_bits_pg.sv
// Generate/propagate network for the 4-bit CLA: per-bit P/G, flat carries C1..C4
// and the group PG/GG terms used by a parent lookahead level.
module cla_4_bits_pg
  import cla_4_bits_pkg::*;
(
  input  nibble_t    a,
  input  nibble_t    b,
  input  logic       cin,
  output nibble_t    p,
  output nibble_t    g,
  output logic [4:1] c,
  output logic       pg,
  output logic       gg
);

  always_comb begin
    g = a & b;
    p = a ^ b;

    // Every carry is a flat sum-of-products so no term waits on a lower carry.
    c[1] = g[0]
         | (p[0] & cin);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);

    pg = &p;
    gg = g[3]
       | (p[3] & g[2])
       | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/cla_4_bits.sv
// 4-bit carry-lookahead adder: combinational Sum/Cout/PG/GG plus a registered
// copy of Sum/Cout for pipelined consumers.
module cla_4_bits
  import cla_4_bits_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic       PG,
  output logic       GG,
  output logic [3:0] sum_q,
  output logic       cout_q
);

  nibble_t    p;
  nibble_t    g;
  logic [4:1] c;
  nibble_t    sum_d;
  logic       cout_d;

  cla_4_bits_pg u_pg (
    .a   (A),
    .b   (B),
    .cin (Cin),
    .p   (p),
    .g   (g),
    .c   (c),
    .pg  (PG),
    .gg  (GG)
  );

  always_comb begin
    sum_d  = p ^ {c[3:1], Cin};
    cout_d = c[4];
    Sum    = sum_d;
    Cout   = cout_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

endmodule

// File: tb/tb_cla_4_bits.sv
// Self-checking bench for cla_4_bits: directed vectors, exhaustive sweep,
// random vectors and async reset, all against an arithmetic reference.
module tb_cla_4_bits;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] Sum;
  logic       Cout;
  logic       PG;
  logic       GG;
  logic [3:0] sum_q;
  logic       cout_q;

  int unsigned total;
  int unsigned bad;

  cla_4_bits dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .Sum    (Sum),
    .Cout   (Cout),
    .PG     (PG),
    .GG     (GG),
    .sum_q  (sum_q),
    .cout_q (cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (A=%0d B=%0d Cin=%0d)", tag, got, exp, A, B, Cin);
    end
  endtask

  // Reference: plain integer addition; group terms from the bare A+B value.
  function automatic logic [4:0] ref_total(input int unsigned a, input int unsigned b, input int unsigned ci);
    int unsigned s;
    s = a + b + ci;
    return s[4:0];
  endfunction

  function automatic logic ref_pg(input int unsigned a, input int unsigned b);
    return (a + b) == 15;
  endfunction

  function automatic logic ref_gg(input int unsigned a, input int unsigned b);
    return (a + b) > 15;
  endfunction

  // Drive between edges, check the combinational outputs, then check the
  // register after the next rising edge has captured this vector.
  task automatic apply(input int unsigned a, input int unsigned b, input int unsigned ci, input string tag);
    logic [4:0] t;
    @(negedge clk);
    A   = 4'(a);
    B   = 4'(b);
    Cin = 1'(ci);
    t   = ref_total(a, b, ci);
    #1;
    check_eq({tag, "_sum"},  {4'b0, Sum},  {4'b0, t[3:0]});
    check_eq({tag, "_cout"}, {7'b0, Cout}, {7'b0, t[4]});
    check_eq({tag, "_pg"},   {7'b0, PG},   {7'b0, ref_pg(a, b)});
    check_eq({tag, "_gg"},   {7'b0, GG},   {7'b0, ref_gg(a, b)});
    @(posedge clk);
    #1;
    check_eq({tag, "_sum_q"},  {4'b0, sum_q},  {4'b0, t[3:0]});
    check_eq({tag, "_cout_q"}, {7'b0, cout_q}, {7'b0, t[4]});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    A     = 4'd0;
    B     = 4'd0;
    Cin   = 1'b0;

    // Reset state before and across a clock edge.
    #3;
    check_eq("rst_sum_q",  {4'b0, sum_q},  8'd0);
    check_eq("rst_cout_q", {7'b0, cout_q}, 8'd0);
    A = 4'd3; B = 4'd6; Cin = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_hold_sum_q", {4'b0, sum_q}, 8'd0);
    check_eq("rst_comb_sum",   {4'b0, Sum},   8'd10);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-derived expectations.
    apply(0, 0, 0, "z0");
    check_eq("z0_lit", {3'b0, Cout, Sum}, 8'd0);
    apply(0, 0, 1, "z1");
    check_eq("z1_lit", {3'b0, Cout, Sum}, 8'd1);
    apply(1, 1, 1, "ones");
    check_eq("ones_lit", {3'b0, Cout, Sum}, 8'd3);
    apply(3, 6, 1, "t36");
    check_eq("t36_lit", {3'b0, Cout, Sum}, 8'd10);
    apply(4, 2, 0, "t42");
    check_eq("t42_lit", {3'b0, Cout, Sum}, 8'd6);
    apply(12, 3, 1, "chain");
    check_eq("chain_lit", {3'b0, Cout, Sum}, 8'd16);
    apply(15, 1, 0, "wrap0");
    check_eq("wrap0_lit", {3'b0, Cout, Sum}, 8'd16);
    apply(15, 1, 1, "wrap1");
    check_eq("wrap1_lit", {3'b0, Cout, Sum}, 8'd17);
    apply(15, 15, 1, "max");
    check_eq("max_lit", {3'b0, Cout, Sum}, 8'd31);
    apply(15, 0, 0, "grp_p");
    check_eq("grp_p_lit", {6'b0, PG, GG}, 8'b10);
    apply(8, 8, 0, "grp_g");
    check_eq("grp_g_lit", {6'b0, PG, GG}, 8'b01);
    apply(5, 10, 1, "prop");
    check_eq("prop_lit", {2'b0, PG, GG, Cout, Sum[2:0]}, 8'b0010_1000);

    // Register path and asynchronous reset between edges.
    apply(3, 6, 0, "reg");
    check_eq("reg_lit", {3'b0, cout_q, sum_q}, 8'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_sum_q",  {4'b0, sum_q},  8'd0);
    check_eq("arst_cout_q", {7'b0, cout_q}, 8'd0);
    check_eq("arst_sum",    {4'b0, Sum},    8'd9);
    @(posedge clk);
    #1;
    check_eq("arst_hold_sum_q", {4'b0, sum_q}, 8'd0);
    check_eq("arst_hold_sum",   {4'b0, Sum},   8'd9);
    @(negedge clk);
    rst_n = 1'b1;
    apply(7, 7, 1, "post_rst");

    // Exhaustive sweep of all 512 input combinations.
    for (int unsigned ci = 0; ci < 2; ci++)
      for (int unsigned a = 0; a < 16; a++)
        for (int unsigned b = 0; b < 16; b++)
          apply(a, b, ci, "sweep");

    // Random vectors.
    for (int unsigned i = 0; i < 200; i++)
      apply($urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(1, 0), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
